// File: rtl/memory_sequencer.sv
// Initiator side of the dual-space word memory: a stallable instruction fetch
// stream plus a valid/ready load/store request port with a one-cycle response.
module memory_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_address,
  input  logic [15:0] req_value,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  input  logic        instruction_ready,
  output logic        instruction_valid,
  output logic [15:0] instruction,
  output logic [15:0] instruction_pc,
  output logic [15:0] program_counter,
  output logic [15:0] address,
  output logic [15:0] value,
  output logic        memory_store_enable,
  output logic        stack_store_enable,
  input  logic [15:0] current_instruction,
  input  logic [15:0] at_memory,
  input  logic [15:0] at_stack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] pc;

  assign req_ready  = ((state == IDLE) || (state == DONE)) && !reset;
  assign resp_valid = (state == DONE);
  assign resp_data  = op_q[1] ? at_stack : at_memory;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      op_q                <= '0;
      address             <= '0;
      value               <= '0;
      memory_store_enable <= 1'b0;
      stack_store_enable  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req_valid) begin
            op_q                <= req_op;
            address             <= req_address;
            value               <= req_value;
            memory_store_enable <= (req_op == 2'b01);
            stack_store_enable  <= (req_op == 2'b11);
            state               <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          memory_store_enable <= 1'b0;
          stack_store_enable  <= 1'b0;
          state               <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // While stalled, re-present the held address so the memory keeps returning that word.
  assign program_counter = (instruction_valid && !instruction_ready) ? instruction_pc : pc;
  assign instruction     = current_instruction;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc                <= RESET_PC;
      instruction_valid <= 1'b0;
      instruction_pc    <= '0;
    end else if (pc_load) begin
      pc                <= pc_target;
      instruction_valid <= 1'b0;
    end else if (!instruction_valid || instruction_ready) begin
      instruction_pc    <= pc;
      instruction_valid <= 1'b1;
      pc                <= pc + 16'd1;
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer with a behavioural dual-space memory and a
// response scoreboard.
module tb_memory_sequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_address;
  logic [15:0] req_value;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        instruction_ready;
  logic        instruction_valid;
  logic [15:0] instruction;
  logic [15:0] instruction_pc;
  logic [15:0] program_counter;
  logic [15:0] address;
  logic [15:0] value;
  logic        memory_store_enable;
  logic        stack_store_enable;
  logic [15:0] current_instruction;
  logic [15:0] at_memory;
  logic [15:0] at_stack;

  logic [15:0] mem_space   [0:65535];
  logic [15:0] stack_space [0:65535];
  logic [15:0] exp_q [$];

  int unsigned total_checks = 0;
  int unsigned passed_checks = 0;

  memory_sequencer #(.RESET_PC(16'h0010)) dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op              (req_op),
    .req_address         (req_address),
    .req_value           (req_value),
    .resp_valid          (resp_valid),
    .resp_data           (resp_data),
    .pc_load             (pc_load),
    .pc_target           (pc_target),
    .instruction_ready   (instruction_ready),
    .instruction_valid   (instruction_valid),
    .instruction         (instruction),
    .instruction_pc      (instruction_pc),
    .program_counter     (program_counter),
    .address             (address),
    .value               (value),
    .memory_store_enable (memory_store_enable),
    .stack_store_enable  (stack_store_enable),
    .current_instruction (current_instruction),
    .at_memory           (at_memory),
    .at_stack            (at_stack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle-latency memory; a store at an edge is visible to reads at that same edge.
  always @(posedge clock) begin
    if (memory_store_enable) mem_space[address] <= value;
    if (stack_store_enable)  stack_space[address] <= value;
    current_instruction <= (memory_store_enable && address == program_counter) ? value
                                                                               : mem_space[program_counter];
    at_memory <= memory_store_enable ? value : mem_space[address];
    at_stack  <= stack_store_enable  ? value : stack_space[address];
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  always @(negedge clock) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 16'(exp_q.size()), 16'd1);
      else check("resp_data", resp_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] v,
                      input logic [15:0] expected);
    int unsigned waited = 0;
    while (!req_ready && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    check("req_ready_wait", {15'd0, req_ready}, 16'd1);
    req_valid   = 1'b1;
    req_op      = op;
    req_address = a;
    req_value   = v;
    exp_q.push_back(expected);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clock);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_address = '0; req_value = '0;
    pc_load = 1'b0; pc_target = '0; instruction_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_space[i]   = 16'h0000;
      stack_space[i] = 16'h0000;
    end
    mem_space[16'h0010] = 16'h00A1;
    mem_space[16'h0011] = 16'h00A2;
    mem_space[16'h0012] = 16'h00A3;
    mem_space[16'h0020] = 16'h7020;
    mem_space[16'h0100] = 16'h7100;
    mem_space[16'hFFFF] = 16'h7FFF;
    mem_space[16'h0000] = 16'h7000;
    mem_space[16'h0030] = 16'h5555;

    repeat (2) @(negedge clock);
    check("rst_req_ready", {15'd0, req_ready}, 16'd0);
    check("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
    check("rst_instr_valid", {15'd0, instruction_valid}, 16'd0);
    check("rst_program_counter", program_counter, 16'h0010);
    check("rst_instruction_pc", instruction_pc, 16'h0000);
    check("rst_address", address, 16'h0000);
    check("rst_value", value, 16'h0000);
    check("rst_enables", {14'd0, memory_store_enable, stack_store_enable}, 16'd0);

    // Reset fetch stream
    instruction_ready = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("fetch_valid", {15'd0, instruction_valid}, 16'd1);
      check("fetch_pc", instruction_pc, 16'h0010 + 16'(i));
      check("fetch_word", instruction, 16'h00A1 + 16'(i));
    end

    // Stall and redirect
    pc_load = 1'b1; pc_target = 16'h0020;
    @(negedge clock);
    check("redirect_invalid", {15'd0, instruction_valid}, 16'd0);
    pc_load = 1'b0; instruction_ready = 1'b0;
    @(negedge clock);
    check("stall_first_pc", instruction_pc, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_word", instruction, 16'h7020);
      check("stall_program_counter", program_counter, 16'h0020);
      check("stall_pc", instruction_pc, 16'h0020);
    end
    pc_load = 1'b1; pc_target = 16'h0100;
    @(negedge clock);
    check("redirect2_invalid", {15'd0, instruction_valid}, 16'd0);
    pc_load = 1'b0; instruction_ready = 1'b1;
    @(negedge clock);
    check("redirect2_pc", instruction_pc, 16'h0100);
    check("redirect2_word", instruction, 16'h7100);

    // Wrap
    pc_load = 1'b1; pc_target = 16'hFFFF;
    @(negedge clock);
    check("wrap_invalid", {15'd0, instruction_valid}, 16'd0);
    pc_load = 1'b0;
    @(negedge clock);
    check("wrap_pc_ffff", instruction_pc, 16'hFFFF);
    check("wrap_word_ffff", instruction, 16'h7FFF);
    @(negedge clock);
    check("wrap_pc_0000", instruction_pc, 16'h0000);
    check("wrap_word_0000", instruction, 16'h7000);

    // Store/load memory
    send(2'b01, 16'h0040, 16'hBEEF, 16'hBEEF);
    check("store_mse_on", {15'd0, memory_store_enable}, 16'd1);
    check("store_address", address, 16'h0040);
    check("store_value", value, 16'hBEEF);
    @(negedge clock);
    check("store_mse_off", {15'd0, memory_store_enable}, 16'd0);
    send(2'b00, 16'h0040, 16'h0000, 16'hBEEF);
    drain();

    // Stack isolation
    send(2'b11, 16'h0005, 16'h1234, 16'h1234);
    check("stack_sse_on", {15'd0, stack_store_enable}, 16'd1);
    check("stack_mse_off", {15'd0, memory_store_enable}, 16'd0);
    send(2'b00, 16'h0005, 16'h0000, 16'h0000);
    send(2'b10, 16'h0005, 16'h0000, 16'h1234);
    drain();

    // Back-to-back loads with req_valid held
    req_valid = 1'b1; req_op = 2'b00; req_address = 16'h0040;
    check("b2b_ready_idle", {15'd0, req_ready}, 16'd1);
    exp_q.push_back(16'hBEEF);
    @(negedge clock);
    check("b2b_access_ready", {15'd0, req_ready}, 16'd0);
    check("b2b_access_resp", {15'd0, resp_valid}, 16'd0);
    @(negedge clock);
    check("b2b_done1_resp", {15'd0, resp_valid}, 16'd1);
    check("b2b_done_ready", {15'd0, req_ready}, 16'd1);
    req_op = 2'b10; req_address = 16'h0005;
    exp_q.push_back(16'h1234);
    @(negedge clock);
    req_valid = 1'b0;
    check("b2b_gap_resp", {15'd0, resp_valid}, 16'd0);
    @(negedge clock);
    check("b2b_done2_resp", {15'd0, resp_valid}, 16'd1);
    @(negedge clock);
    check("b2b_idle_resp", {15'd0, resp_valid}, 16'd0);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    // Reset during ACCESS cancels the store
    req_valid = 1'b1; req_op = 2'b01; req_address = 16'h0030; req_value = 16'hAAAA;
    @(negedge clock);
    req_valid = 1'b0;
    check("abort_mse_on", {15'd0, memory_store_enable}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_mse_async", {15'd0, memory_store_enable}, 16'd0);
    check("abort_ready", {15'd0, req_ready}, 16'd0);
    check("abort_resp", {15'd0, resp_valid}, 16'd0);
    check("abort_address", address, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    send(2'b00, 16'h0030, 16'h0000, 16'h5555);
    drain();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
# memory_sequencer

Initiator side of the datapath memory interface: drives `program_counter`, `address`, `value`, `memory_store_enable` and `stack_store_enable` into the dual-space (memory/stack) word memory, and consumes its registered outputs. The memory has one-cycle read latency: it samples its inputs at a rising edge, stores before it reads, and presents `current_instruction`, `at_memory` and `at_stack` after that edge. The block sits between the fetch/execute logic and the memory. It provides a stallable instruction stream and a valid/ready load/store request port with a one-cycle response pulse.

## Interface
- `RESET_PC`, 16'h0000, fetch address after reset.
- `clock` in 1 — sole clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — data request pending.
- `req_ready` out 1 — request accepted at edge when `req_valid && req_ready`.
- `req_op` in 2 — 00 load memory, 01 store memory, 10 load stack, 11 store stack.
- `req_address` in 16 — word address.
- `req_value` in 16 — store data.
- `resp_valid` out 1 — one-cycle response pulse.
- `resp_data` out 16 — word read at the request address; for stores, the read-back value.
- `pc_load` in 1 — redirect fetch.
- `pc_target` in 16 — redirect address.
- `instruction_ready` in 1 — consumer takes `instruction` at this edge.
- `instruction_valid` out 1 — `instruction` is valid.
- `instruction` out 16 — fetched word; pass-through of `current_instruction`.
- `instruction_pc` out 16 — address of `instruction`.
- `program_counter`, `address`, `value` out 16 — memory-side request signals.
- `memory_store_enable`, `stack_store_enable` out 1 — memory-side write strobes.
- `current_instruction`, `at_memory`, `at_stack` in 16 — memory read data.

## Operation
- **Data FSM states: IDLE, ACCESS, DONE.**
  - `req_ready` = (IDLE or DONE) and not `reset`.
  - On accept:
    - latch `req_op`;
    - register `address` ← `req_address` and `value` ← `req_value`;
    - assert the store enable selected by the op: `memory_store_enable` for 01, `stack_store_enable` for 11;
    - go to ACCESS.
  - ACCESS lasts exactly one cycle, and the memory acts at the edge that ends it. At that edge: both enables ← 0, go to DONE.
  - DONE: `resp_valid` = 1.
    - `resp_data` = `at_stack` if latched op[1] is set, else `at_memory` (combinational mux).
    - A new accept in DONE goes to ACCESS; otherwise go to IDLE.
    - `address` and `value` hold their values until the next accept.
- **Fetch.** Register `pc` holds the next address to present.
  - `program_counter` = `instruction_pc` when `instruction_valid && !instruction_ready` (stall: re-read the held word), else `pc`.
  - At each edge, in priority order:
    1. `pc_load`: `pc` ← `pc_target`, `instruction_valid` ← 0.
    2. Else if `!instruction_valid || instruction_ready`: `instruction_pc` ← `pc`, `instruction_valid` ← 1, `pc` ← `pc` + 1 (mod 2^16; FFFF wraps to 0000).
    3. Else: hold.
  - When valid, `instruction` = `current_instruction` = memory[`instruction_pc`].
- **Simultaneous events.**
  - `pc_load` beats `instruction_ready`.
  - A store and a fetch to the same address at the same edge: the fetch returns the new value, because the memory stores before it reads. The same holds for a stalled re-read.
  - Fetch and data requests are independent. There is no arbitration; they use separate memory ports.

## Timing
- **Reset values:**
  - Data side: state IDLE, `req_ready` 0 while reset is held, `resp_valid` 0, `address` 0, `value` 0, both enables 0.
  - Fetch side: `pc` = `RESET_PC`, `instruction_valid` 0, `instruction_pc` 0, so `program_counter` = `RESET_PC`.
- Data latency: accept at edge E0, memory access at E1, `resp_valid` high during the cycle after E1. Peak throughput is one request per 2 cycles.
- Fetch latency: first `instruction_valid` follows the first edge after reset deasserts, with `instruction_pc` = `RESET_PC`. Sustained rate is one word per cycle while `instruction_ready` = 1. After `pc_load` at edge E, `instruction_valid` = 0 for one cycle, and the target word is valid after E+1.
- **Reset mid-operation:** enables drop asynchronously, so a store in ACCESS is cancelled if reset asserts before E1. No response is produced for an in-flight request.
- `resp_valid` is never high for more than one cycle per accepted request.

## Test plan
- **Reset fetch:** `RESET_PC`=0010, memory[0010..0012]=A1,A2,A3, `instruction_ready`=1 → `instruction` A1,A2,A3 on consecutive cycles with `instruction_pc` 0010,0011,0012.
- **Store/load memory:** store 01 to addr 0040 value BEEF, then load 00 addr 0040 → first response `resp_data`=BEEF; second `resp_data`=BEEF; `memory_store_enable` high exactly one cycle.
- **Stack isolation:** store stack 0005←1234, load memory 0005 (preloaded 0000) → 0000; load stack 0005 → 1234.
- **Stall and redirect:** hold `instruction_ready`=0 for 3 cycles at `instruction_pc` 0020 → `instruction` stable, `program_counter`=0020. Then `pc_load` with `pc_target`=0100 → one invalid cycle, then `instruction_pc`=0100.
- **Wrap and back-to-back:** `pc_target`=FFFF → `instruction_pc` sequence FFFF,0000. `req_valid` held with 2 loads → accepts at IDLE and DONE, 2 `resp_valid` pulses 2 cycles apart.
- **Reset during ACCESS:** assert `reset` in ACCESS of a store 0030←AAAA (memory[0030]=5555) → enable drops at once; later load of 0030 returns 5555.
